// File: rtl/muldiv_seq_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO write path.
// Shift-add multiplier / restoring divider, one bit per cycle, single registered write pulse.
module muldiv_seq_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  input  logic              hi_used_id,
  input  logic              lo_used_id,
  output logic              busy,
  output logic              stall_req,
  output logic              hi_we,
  output logic              lo_we,
  output logic [DATA_W-1:0] hi_wdata,
  output logic [DATA_W-1:0] lo_wdata,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   acc_hi;
  logic [DATA_W-1:0]   acc_lo;
  logic [DATA_W-1:0]   opb;
  logic                is_div;
  logic                neg_q;
  logic                neg_r;
  logic                div_zero;

  // Operand magnitudes; op[0] selects the unsigned variants.
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   abs_a, abs_b;
  assign a_neg = ~op[0] & src_a[DATA_W-1];
  assign b_neg = ~op[0] & src_b[DATA_W-1];
  assign abs_a = a_neg ? -src_a : src_a;
  assign abs_b = b_neg ? -src_b : src_b;

  // Multiply step: {acc_hi, acc_lo} shifts right, acc_lo holds the remaining multiplier bits.
  logic [DATA_W:0]     mul_sum;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);

  // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic                div_ge;
  assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
  assign div_ge    = div_shift >= {1'b0, opb};
  assign div_diff  = div_shift - {1'b0, opb};

  logic [2*DATA_W-1:0] prod_raw, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  assign prod_raw = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod_raw : prod_raw;
  // A zero divisor leaves an all-ones quotient that must not be negated.
  assign quo_fix  = (neg_q && !div_zero) ? -acc_lo : acc_lo;
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;

  assign busy      = (state != StIdle);
  assign stall_req = busy & (start | hi_used_id | lo_used_id);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_wdata <= '0;
      lo_wdata <= '0;
      hi_we    <= 1'b0;
      lo_we    <= 1'b0;
      done     <= 1'b0;
    end else begin
      hi_we <= 1'b0;
      lo_we <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start && !flush) begin
            state    <= StCalc;
            cnt      <= CNT_W'(DATA_W);
            acc_hi   <= '0;
            acc_lo   <= abs_a;
            opb      <= abs_b;
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (src_b == '0);
          end
        end
        StCalc: begin
          if (flush) begin
            state <= StIdle;
          end else begin
            cnt <= cnt - 1'b1;
            if (is_div) begin
              acc_hi <= div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
              acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
            end else begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_W-1:1]};
            end
            if (cnt == CNT_W'(1)) state <= StFix;
          end
        end
        StFix: begin
          if (flush) begin
            state <= StIdle;
          end else begin
            hi_wdata <= is_div ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
            lo_wdata <= is_div ? quo_fix : prod_fix[DATA_W-1:0];
            hi_we    <= 1'b1;
            lo_we    <= 1'b1;
            done     <= 1'b1;
            state    <= StDone;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed-vector bench for muldiv_seq_ctrl: latency, arithmetic corner cases, stall, flush, reset.
module tb_muldiv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        hi_used_id = 1'b0;
  logic        lo_used_id = 1'b0;
  logic        busy, stall_req, hi_we, lo_we, done;
  logic [31:0] hi_wdata, lo_wdata;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

  muldiv_seq_ctrl #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .hi_used_id (hi_used_id),
    .lo_used_id (lo_used_id),
    .busy       (busy),
    .stall_req  (stall_req),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .hi_wdata   (hi_wdata),
    .lo_wdata   (lo_wdata),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present op in the current cycle (T) with the unit idle; expect strobes in cycle T+34.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int k;
    op = o; src_a = a; src_b = b; start = 1'b1;
    step();
    start = 1'b0;
    k = 1;
    while (!hi_we && k < 40) begin
      step();
      k++;
    end
    check_eq({tag, "_lat"}, 70'(k), 70'(34));
    check_eq({tag, "_strobes"}, 70'({hi_we, lo_we, done}), 70'(3'b111));
    check_eq({tag, "_hi"}, 70'(hi_wdata), 70'(exp_hi));
    check_eq({tag, "_lo"}, 70'(lo_wdata), 70'(exp_lo));
    step();
    check_eq({tag, "_idle"}, 70'({busy, hi_we}), 70'(2'b00));
  endtask

  logic [69:0] all_out;
  assign all_out = {busy, stall_req, hi_we, lo_we, done, hi_wdata, lo_wdata};

  initial begin
    int writes;
    int bad;
    int k;
    logic [31:0] last_hi, last_lo;

    step();
    step();
    check_eq("reset_outputs", all_out, '0);
    rst = 1'b0;
    step();

    // Arithmetic vectors
    run_op("multu_ff_x2", OpMultu, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_m3_x5", OpMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_m1_m1", OpMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    run_op("mult_min_min", OpMult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
    run_op("divu_7_0", OpDivu, 32'd7, 32'd0, 32'h7, 32'hFFFF_FFFF);
    run_op("div_m7_0", OpDiv, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_min_m1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu_big_16", OpDivu, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);

    // flush and start together: op dropped
    op = OpMult; src_a = 32'd3; src_b = 32'd3; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check_eq("flush_start_drop", 70'(busy), 70'(0));

    // Flush mid-DIV: busy drops at T+11, no strobe through T+40, write data unchanged
    last_hi = hi_wdata; last_lo = lo_wdata;
    op = OpDiv; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_busy", 70'(busy), 70'(0));
    writes = 0;
    for (int c = 11; c <= 40; c++) begin
      if (hi_we || lo_we) writes++;
      step();
    end
    check_eq("flush_no_write", 70'(writes), 70'(0));
    check_eq("flush_keep_data", 70'({hi_wdata, lo_wdata}), 70'({last_hi, last_lo}));

    // Stall: ID reads HI from T+5; second op held from T+20, accepted at T+35
    op = OpDiv; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    hi_used_id = 1'b1;
    bad = 0;
    writes = 0;
    for (int c = 5; c <= 34; c++) begin
      if (c == 20) begin
        op = OpDivu; src_a = 32'd50; src_b = 32'd6; start = 1'b1;
      end
      #1;
      if (!stall_req) bad++;
      if (c == 34 && hi_we && hi_wdata == 32'd2 && lo_wdata == 32'd14) writes++;
      step();
    end
    check_eq("stall_held", 70'(bad), 70'(0));
    check_eq("stall_first_result", 70'(writes), 70'(1));
    #1;
    check_eq("stall_release", 70'({stall_req, busy}), 70'(2'b00));
    step();
    start = 1'b0;
    k = 1;
    while (!hi_we && k < 40) begin
      if (k == 5) hi_used_id = 1'b0;
      step();
      k++;
    end
    hi_used_id = 1'b0;
    check_eq("held_start_lat", 70'(k), 70'(34));
    check_eq("held_start_res", 70'({hi_wdata, lo_wdata}), 70'({32'd2, 32'd8}));
    step();

    // LO read and start both stall while busy
    op = OpMultu; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    lo_used_id = 1'b1;
    #1;
    check_eq("stall_lo_used", 70'(stall_req), 70'(1));
    lo_used_id = 1'b0;
    #1;
    check_eq("no_stall_idle_inputs", 70'(stall_req), 70'(0));
    while (busy) step();

    // Reset mid-MULT at T+15: outputs zero at T+16, no write
    op = OpMult; src_a = 32'd12345; src_b = 32'd678; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 15; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_mid_outputs", all_out, '0);
    writes = 0;
    for (int c = 16; c <= 40; c++) begin
      if (hi_we || lo_we) writes++;
      step();
    end
    check_eq("rst_mid_no_write", 70'(writes), 70'(0));
    run_op("after_rst_multu", OpMultu, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
